dram_cmd_responder: RTL
=======================

DRAM_CMD_RESPONDER -- requirements
Module: dram_cmd_responder

Interface
REQ-001 Parameter RD_LAT, default 4, sets the read-data latency in cycles after an accepted RD (legal range 1..15).
REQ-002 Parameter DATA_KEY, default 32'hA5A5_A5A5, is the XOR key for the synthetic read pattern.
REQ-003 Ports, in this order:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- command  in  3  controller command (CMD_NOP/PRE/ACT/RD/WR, shared encoding).
- address  in  32  row[29:16], bg[15:14], bank[13:12], col[11:4].
- write_data  in  32  data accompanying WR.
- rd_valid  out  1  read-data strobe.
- rd_data  out  32  read data, valid when rd_valid=1.
- err_valid  out  1  one-cycle violation pulse.
- err_code  out  3  violation class, valid with err_valid.
- err_count  out  16  saturating violation counter.
- open_mask  out  16  bit {bg,bank}=1 when that bank is open.
- last_wr_data  out  32  write_data of the most recent accepted WR.

Function
REQ-004 Bank index is {bg,bank} (0..15); each bank holds is_open, open_row[13:0] and countdown timers t_can_act, t_can_pre, t_can_rd, t_can_wr.
REQ-005 Each non-zero timer decrements by 1 per cycle, floors at 0; a command is timing-legal only if its relevant timer is 0 in the sampling cycle.
REQ-006 Accepted ACT: is_open=1, open_row=row; t_can_rd=t_can_wr=tRCD, t_can_pre=tRAS; other banks t_can_act=max(cur,tRRD_L) same BG, max(cur,tRRD_S) other BG.
REQ-007 Accepted PRE to an open bank: is_open=0, t_can_act=max(cur,tRP); PRE to a closed bank is a legal no-op.
REQ-008 Accepted RD: own t_can_pre=max(cur,tRTP); every bank t_can_rd=max(cur, tCCD_L same BG / tCCD_S other BG); every bank t_can_wr=max(cur,tRTW).
REQ-009 Accepted WR: own t_can_pre=max(cur,tWR); every bank t_can_wr=max(cur, tCCD_L same BG / tCCD_S other BG); last_wr_data<=write_data.
REQ-010 Violation codes, first match wins: 5 unknown encoding; 1 ACT to open bank; 2 RD/WR to closed bank; 3 RD/WR row != open_row; 4 relevant timer non-zero; 0 none.
REQ-011 A violating command is ignored for state: no timer, bank, data or pipeline update.
REQ-012 err_valid/err_code are registered: asserted the cycle after the offending command, for one cycle.
REQ-013 err_count increments on every err_valid and saturates at 16'hFFFF.
REQ-014 Accepted RD sampled in cycle N gives rd_valid=1 in cycle N+RD_LAT, rd_data=address^DATA_KEY.
REQ-015 The read pipeline is a shift register carrying one slot per cycle; back-to-back RDs each produce their own pulse, in order.
REQ-016 open_mask reflects the registered is_open bits (updates the cycle after ACT/PRE).
REQ-017 CMD_NOP changes nothing except timer decrement and the pipeline shift.

Reset
REQ-018 While reset=0 at a clock edge: all banks closed, open_row=0, all timers 0, pipeline cleared.
REQ-019 During reset, also: rd_valid=0, rd_data=0, err_valid=0, err_code=0, err_count=0, open_mask=0, last_wr_data=0.
REQ-020 Reset mid-operation discards pending read slots; no rd_valid follows a reset.

Structure
REQ-021 CMD encodings, timing constants and address field positions come from the existing shared timing/abstraction headers.
REQ-022 Error-code enum and the bank-state struct live in shared package dram_pkg.
REQ-023 Per-bank state and timers live in sub-module dram_bank_tracker, instantiated 16 times.
REQ-024 Cross-bank max() updates and violation priority live in the top level.

Verification
REQ-025 Cold read: ACT row 0x1234 bank 0, RD col 0x10 after tRCD -> no error; rd_valid at RD+4; rd_data=addr^A5A5A5A5.
REQ-026 Early read: ACT, then RD at tRCD-1 -> err_code 4, err_count 1, no rd_valid; RD at tRCD accepted.
REQ-027 Row conflict: bank 0 open row 0x1234, RD row 0x1678 -> code 3; PRE after tRTP, ACT after tRP, RD after tRCD -> accepted.
REQ-028 Closed bank / double ACT: RD to bank 5 closed -> code 2; ACT bank 0 twice -> code 1; open_mask only bit 0.
REQ-029 Bank groups: ACT bank 0 then bank 1 at tRRD_L-1 -> code 4; ACT BG1 bank 4 at tRRD_S -> accepted.
REQ-030 Reset with 3 reads in flight -> zero rd_valid afterwards, err_count=0, open_mask=0; force 65536 errors -> err_count holds 0xFFFF.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared DRAM definitions: command encodings, timing constants, address fields,
// error codes and per-bank state shared by the command responder and its bank trackers.
package dram_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_PRE = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  localparam int unsigned T_RCD   = 5;
  localparam int unsigned T_RAS   = 10;
  localparam int unsigned T_RP    = 4;
  localparam int unsigned T_RRD_L = 4;
  localparam int unsigned T_RRD_S = 2;
  localparam int unsigned T_CCD_L = 4;
  localparam int unsigned T_CCD_S = 1;
  localparam int unsigned T_RTW   = 6;
  localparam int unsigned T_RTP   = 3;
  localparam int unsigned T_WR    = 6;

  localparam int unsigned ROW_MSB  = 29;
  localparam int unsigned ROW_LSB  = 16;
  localparam int unsigned BG_MSB   = 15;
  localparam int unsigned BG_LSB   = 14;
  localparam int unsigned BANK_MSB = 13;
  localparam int unsigned BANK_LSB = 12;

  typedef logic [3:0] timer_t;

  // Timers are loaded with T-1 on the accepting edge so the next command of that
  // kind is legal exactly T cycles after the one that armed it.
  localparam timer_t LD_RCD   = timer_t'(T_RCD - 1);
  localparam timer_t LD_RAS   = timer_t'(T_RAS - 1);
  localparam timer_t LD_RP    = timer_t'(T_RP - 1);
  localparam timer_t LD_RRD_L = timer_t'(T_RRD_L - 1);
  localparam timer_t LD_RRD_S = timer_t'(T_RRD_S - 1);
  localparam timer_t LD_CCD_L = timer_t'(T_CCD_L - 1);
  localparam timer_t LD_CCD_S = timer_t'(T_CCD_S - 1);
  localparam timer_t LD_RTW   = timer_t'(T_RTW - 1);
  localparam timer_t LD_RTP   = timer_t'(T_RTP - 1);
  localparam timer_t LD_WR    = timer_t'(T_WR - 1);

  typedef enum logic [2:0] {
    ErrNone    = 3'd0,
    ErrActOpen = 3'd1,
    ErrClosed  = 3'd2,
    ErrRowMiss = 3'd3,
    ErrTiming  = 3'd4,
    ErrUnknown = 3'd5
  } err_code_e;

  typedef struct packed {
    logic        is_open;
    logic [13:0] open_row;
    timer_t      t_can_act;
    timer_t      t_can_pre;
    timer_t      t_can_rd;
    timer_t      t_can_wr;
  } bank_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_slot_t;

  function automatic timer_t tmax(timer_t a, timer_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// One DRAM bank: open/row state plus four countdown timers, each floored by a
// minimum supplied by the top level on the cycle a command is accepted.
module dram_bank_tracker
  import dram_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        act_i,
  input  logic        pre_i,
  input  logic [13:0] row_i,
  input  timer_t      act_min_i,
  input  timer_t      pre_min_i,
  input  timer_t      rd_min_i,
  input  timer_t      wr_min_i,
  output bank_state_t state_o
);

  bank_state_t state_q, state_d;

  function automatic timer_t dec(timer_t t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  always_comb begin
    state_d           = state_q;
    state_d.t_can_act = tmax(dec(state_q.t_can_act), act_min_i);
    state_d.t_can_pre = tmax(dec(state_q.t_can_pre), pre_min_i);
    state_d.t_can_rd  = tmax(dec(state_q.t_can_rd), rd_min_i);
    state_d.t_can_wr  = tmax(dec(state_q.t_can_wr), wr_min_i);
    if (act_i) begin
      state_d.is_open  = 1'b1;
      state_d.open_row = row_i;
    end
    if (pre_i) begin
      state_d.is_open = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/dram_cmd_responder.sv
// DRAM command responder: checks controller commands against per-bank state and
// timing, flags violations, and returns a synthetic read pattern after RD_LAT cycles.
module dram_cmd_responder
  import dram_pkg::*;
#(
  parameter int unsigned RD_LAT   = 4,
  parameter logic [31:0] DATA_KEY = 32'hA5A5_A5A5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  command,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [15:0] err_count,
  output logic [15:0] open_mask,
  output logic [31:0] last_wr_data
);

  logic [13:0] row;
  logic [1:0]  bg;
  logic [3:0]  idx;
  assign row = address[ROW_MSB:ROW_LSB];
  assign bg  = address[BG_MSB:BG_LSB];
  assign idx = {bg, address[BANK_MSB:BANK_LSB]};

  bank_state_t bank_st [16];
  bank_state_t sel;
  assign sel = bank_st[idx];

  err_code_e err_d, err_code_q;
  logic      err_valid_q;
  logic      accept, do_act, do_pre, do_rd, do_wr;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] last_wr_q;

  always_comb begin
    err_d = ErrNone;
    case (command)
      CMD_NOP: err_d = ErrNone;
      CMD_ACT: begin
        if (sel.is_open)                err_d = ErrActOpen;
        else if (sel.t_can_act != '0)   err_d = ErrTiming;
      end
      CMD_PRE: begin
        // Precharge of a closed bank is a no-op and never checked for timing.
        if (sel.is_open && sel.t_can_pre != '0) err_d = ErrTiming;
      end
      CMD_RD, CMD_WR: begin
        if (!sel.is_open)               err_d = ErrClosed;
        else if (sel.open_row != row)   err_d = ErrRowMiss;
        else if (((command == CMD_RD) ? sel.t_can_rd : sel.t_can_wr) != '0) err_d = ErrTiming;
      end
      default: err_d = ErrUnknown;
    endcase
  end

  assign accept = (err_d == ErrNone);
  assign do_act = accept && (command == CMD_ACT);
  assign do_pre = accept && (command == CMD_PRE) && sel.is_open;
  assign do_rd  = accept && (command == CMD_RD);
  assign do_wr  = accept && (command == CMD_WR);

  logic [15:0] act_en, pre_en;
  timer_t      act_min [16];
  timer_t      pre_min [16];
  timer_t      rd_min  [16];
  timer_t      wr_min  [16];

  always_comb begin
    for (int b = 0; b < 16; b++) begin
      act_en[b]  = 1'b0;
      pre_en[b]  = 1'b0;
      act_min[b] = '0;
      pre_min[b] = '0;
      rd_min[b]  = '0;
      wr_min[b]  = '0;
      if (do_act) begin
        if (4'(b) == idx) begin
          act_en[b]  = 1'b1;
          rd_min[b]  = LD_RCD;
          wr_min[b]  = LD_RCD;
          pre_min[b] = LD_RAS;
        end else begin
          act_min[b] = (2'(b / 4) == bg) ? LD_RRD_L : LD_RRD_S;
        end
      end
      if (do_pre && (4'(b) == idx)) begin
        pre_en[b]  = 1'b1;
        act_min[b] = LD_RP;
      end
      if (do_rd) begin
        if (4'(b) == idx) pre_min[b] = LD_RTP;
        rd_min[b] = (2'(b / 4) == bg) ? LD_CCD_L : LD_CCD_S;
        wr_min[b] = LD_RTW;
      end
      if (do_wr) begin
        if (4'(b) == idx) pre_min[b] = LD_WR;
        wr_min[b] = (2'(b / 4) == bg) ? LD_CCD_L : LD_CCD_S;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : gen_bank
    dram_bank_tracker u_bank (
      .clk_i     (clk),
      .rst_ni    (reset),
      .act_i     (act_en[g]),
      .pre_i     (pre_en[g]),
      .row_i     (row),
      .act_min_i (act_min[g]),
      .pre_min_i (pre_min[g]),
      .rd_min_i  (rd_min[g]),
      .wr_min_i  (wr_min[g]),
      .state_o   (bank_st[g])
    );
  end

  always_comb begin
    for (int b = 0; b < 16; b++) open_mask[b] = bank_st[b].is_open;
  end

  rd_slot_t [RD_LAT-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = '{valid: do_rd, data: do_rd ? (address ^ DATA_KEY) : '0};
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign err_count_d = ((err_d != ErrNone) && (err_count_q != 16'hFFFF)) ?
                       err_count_q + 16'd1 : err_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ErrNone;
      err_count_q <= '0;
      last_wr_q   <= '0;
    end else begin
      pipe_q      <= pipe_d;
      err_valid_q <= (err_d != ErrNone);
      err_code_q  <= err_d;
      err_count_q <= err_count_d;
      if (do_wr) last_wr_q <= write_data;
    end
  end

  assign rd_valid     = pipe_q[RD_LAT-1].valid;
  assign rd_data      = pipe_q[RD_LAT-1].data;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_count    = err_count_q;
  assign last_wr_data = last_wr_q;

endmodule
